// File: rtl/sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sram_fifo_ctrl
//
// Synchronous FIFO controller sitting directly upstream of a 1r1w SRAM wrapper
// (32x8, dual-bank). It accepts a valid/ready byte stream, writes it into the
// SRAM, reads it back in order and presents a valid/ready stream downstream.
// The one-cycle SRAM read latency is absorbed by a small output stage made of
// the read currently in flight plus a 2-entry holding buffer, so both sides
// sustain one word per cycle. Total capacity is RAM_DEPTH + 2 entries.
//
// Optional feature (compile-time macro SRAM_FIFO_WATERMARK_EN):
//   adds parameter AFULL_THRESH and outputs almost_full / overflow.
//
// Ports:
//   clk           clock for the controller and the SRAM
//   rst           synchronous reset, active-high
//   in_valid      upstream data valid
//   in_ready      space available in the SRAM (registered state only)
//   in_data       upstream data
//   out_valid     head of FIFO is valid
//   out_ready     downstream accepts the head
//   out_data      head data (holds its last value while empty)
//   mem_wen       SRAM write enable
//   mem_wpointer  SRAM write address
//   mem_wdata     SRAM write data
//   mem_ren       SRAM read enable
//   mem_rpointer  SRAM read address
//   mem_rdata     SRAM read data, valid one cycle after mem_ren
//   count         total entries held (SRAM + in-flight read + buffer)
//   almost_full   (macro only) registered, 1 when count >= AFULL_THRESH
//   overflow      (macro only) sticky, set by in_valid while in_ready=0
// -----------------------------------------------------------------------------
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int RAM_DEPTH    = 32,
  parameter int ADDR_WIDTH   = $clog2(RAM_DEPTH),
  parameter int CNT_WIDTH    = $clog2(RAM_DEPTH + 3)
`ifdef SRAM_FIFO_WATERMARK_EN
  ,
  parameter int AFULL_THRESH = RAM_DEPTH - 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_wpointer,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_rpointer,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  count
`ifdef SRAM_FIFO_WATERMARK_EN
  ,
  output logic                  almost_full,
  output logic                  overflow
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam logic [ADDR_WIDTH:0] DEPTH_PTR = (ADDR_WIDTH + 1)'(RAM_DEPTH);

  logic [ADDR_WIDTH:0]  wptr_reg, wptr_next;
  logic [ADDR_WIDTH:0]  rptr_reg, rptr_next;
  logic [ADDR_WIDTH:0]  mem_count;
  logic                 inflight_reg;
  logic [1:0]           buf_occ_reg, buf_occ_next;
  logic [DATA_WIDTH-1:0] buf_data_reg  [2];
  logic [DATA_WIDTH-1:0] buf_data_next [2];

  logic       wr_fire;
  logic       rd_fire;
  logic       pop;
  logic [1:0] stage_occ;   // buffered words + word returning this cycle
  logic [1:0] after_pop;   // output-stage occupancy once this cycle's pop is taken

  // ---------------------------------------------------------------------------
  // Write side, read issue and output stage
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_count = wptr_reg - rptr_reg;

    // Depends only on registered pointers: a pop this cycle never frees space
    // for a write in the same cycle.
    in_ready  = (mem_count != DEPTH_PTR);
    wr_fire   = in_valid & in_ready;

    mem_wen      = wr_fire;
    mem_wpointer = wptr_reg[ADDR_WIDTH-1:0];
    mem_wdata    = in_data;

    // The word returning from the SRAM is logically the tail of the output
    // stage. When the buffer is empty it is presented at the head directly,
    // which gives the two-cycle write-to-output latency.
    out_valid = (buf_occ_reg != 2'd0) | inflight_reg;
    if ((buf_occ_reg == 2'd0) && inflight_reg) begin
      out_data = mem_rdata;
    end else begin
      out_data = buf_data_reg[0];
    end

    pop       = out_valid & out_ready;
    stage_occ = buf_occ_reg + {1'b0, inflight_reg};
    after_pop = stage_occ - {1'b0, pop};

    // Only issue a read if its data is guaranteed a buffer slot next cycle.
    // Registered mem_count means the word written this cycle is never the one
    // being read, so there is no same-address collision.
    rd_fire      = (mem_count != '0) && (after_pop < 2'd2);
    mem_ren      = rd_fire;
    mem_rpointer = rptr_reg[ADDR_WIDTH-1:0];

    wptr_next    = wptr_reg + {{ADDR_WIDTH{1'b0}}, wr_fire};
    rptr_next    = rptr_reg + {{ADDR_WIDTH{1'b0}}, rd_fire};

    // Whatever is left in the output stage after the pop (including a
    // returning word that was not consumed) lands in the buffer.
    buf_occ_next = after_pop;

    buf_data_next[0] = buf_data_reg[0];
    buf_data_next[1] = buf_data_reg[1];
    case (buf_occ_reg)
      2'd0: begin
        // Capture the returning word even if it was popped straight through,
        // so out_data keeps showing the last delivered value while empty.
        if (inflight_reg) begin
          buf_data_next[0] = mem_rdata;
        end
      end
      2'd1: begin
        if (pop) begin
          if (inflight_reg) begin
            buf_data_next[0] = mem_rdata;
          end
        end else if (inflight_reg) begin
          buf_data_next[1] = mem_rdata;
        end
      end
      default: begin
        // Buffer full implies no read in flight; a pop just shifts.
        if (pop) begin
          buf_data_next[0] = buf_data_reg[1];
        end
      end
    endcase

    count = CNT_WIDTH'(mem_count) + CNT_WIDTH'(inflight_reg) + CNT_WIDTH'(buf_occ_reg);
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset drops any read in flight: clearing inflight_reg
  // makes the next mem_rdata beat irrelevant.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_reg     <= '0;
      rptr_reg     <= '0;
      inflight_reg <= 1'b0;
      buf_occ_reg  <= 2'd0;
    end else begin
      wptr_reg     <= wptr_next;
      rptr_reg     <= rptr_next;
      inflight_reg <= rd_fire;
      buf_occ_reg  <= buf_occ_next;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (rst) begin
          buf_data_reg[gi] <= '0;
        end else begin
          buf_data_reg[gi] <= buf_data_next[gi];
        end
      end
    end
  endgenerate

`ifdef SRAM_FIFO_WATERMARK_EN
  // ---------------------------------------------------------------------------
  // Watermark / overflow flags. almost_full is registered from the next-state
  // occupancy so it lines up with count in the same cycle.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH:0]  mem_count_next;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 almost_full_reg;
  logic                 overflow_reg;

  always_comb begin
    mem_count_next = wptr_next - rptr_next;
    count_next     = CNT_WIDTH'(mem_count_next) + CNT_WIDTH'(rd_fire) + CNT_WIDTH'(after_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      almost_full_reg <= (count_next >= CNT_WIDTH'(AFULL_THRESH));
      overflow_reg    <= overflow_reg | (in_valid & ~in_ready);
    end
  end

  assign almost_full = almost_full_reg;
  assign overflow    = overflow_reg;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_fifo_ctrl
//
// Bench for sram_fifo_ctrl with a behavioural 1r1w SRAM (registered read).
// A negedge monitor keeps a scoreboard queue: accepted words are pushed when
// in_valid & in_ready, and compared in order when out_valid & out_ready; it
// also checks count against the scoreboard occupancy every cycle. Scenario
// tasks drive inputs just after posedge and do their own inline checks.
// -----------------------------------------------------------------------------
module tb_sram_fifo_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          mem_wen;
  logic [AW-1:0] mem_wpointer;
  logic [DW-1:0] mem_wdata;
  logic          mem_ren;
  logic [AW-1:0] mem_rpointer;
  logic [DW-1:0] mem_rdata;
  logic [CW-1:0] count;
`ifdef SRAM_FIFO_WATERMARK_EN
  logic          almost_full;
  logic          overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;
  logic [DW-1:0] exp_q [$];

  sram_fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .mem_wen      (mem_wen),
    .mem_wpointer (mem_wpointer),
    .mem_wdata    (mem_wdata),
    .mem_ren      (mem_ren),
    .mem_rpointer (mem_rpointer),
    .mem_rdata    (mem_rdata),
    .count        (count)
`ifdef SRAM_FIFO_WATERMARK_EN
    ,
    .almost_full  (almost_full),
    .overflow     (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: synchronous write, registered read.
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (mem_wen) sram_mem[mem_wpointer] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram_mem[mem_rpointer];
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    if (rst) begin
      exp_q.delete();
    end else if (mon_en) begin
      n_checks++;
      if (count !== CW'(exp_q.size())) begin
        n_fail++;
        $display("FAIL sb_count: count=%0d expected %0d", count, exp_q.size());
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: popped 0x%h with nothing expected", out_data);
        end else begin
          exp_d = exp_q.pop_front();
          if (out_data !== exp_d) begin
            n_fail++;
            $display("FAIL sb_data: out_data=0x%h expected 0x%h", out_data, exp_d);
          end else begin
            $display("pop data=0x%h", out_data);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks += 6;
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL rst_in_ready: %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: %b expected 0", out_valid); end
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data: 0x%h expected 0x00", out_data); end
    if (count !== 6'd0)     begin n_fail++; $display("FAIL rst_count: %0d expected 0", count); end
    if (mem_wen !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_wen: %b expected 0", mem_wen); end
    if (mem_ren !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_ren: %b expected 0", mem_ren); end
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    @(negedge clk);
    n_checks += 4;
    if (mem_wen !== 1'b1)       begin n_fail++; $display("FAIL c0_mem_wen: %b expected 1", mem_wen); end
    if (mem_wpointer !== 5'd0)  begin n_fail++; $display("FAIL c0_wpointer: %0d expected 0", mem_wpointer); end
    if (mem_wdata !== 8'hA5)    begin n_fail++; $display("FAIL c0_wdata: 0x%h expected 0xa5", mem_wdata); end
    if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL c0_out_valid: %b expected 0", out_valid); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (mem_ren !== 1'b1)       begin n_fail++; $display("FAIL c1_mem_ren: %b expected 1", mem_ren); end
    if (mem_rpointer !== 5'd0)  begin n_fail++; $display("FAIL c1_rpointer: %0d expected 0", mem_rpointer); end
    if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL c1_out_valid: %b expected 0", out_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks += 2;
    if (out_valid !== 1'b1)     begin n_fail++; $display("FAIL c2_out_valid: %b expected 1", out_valid); end
    if (out_data !== 8'hA5)     begin n_fail++; $display("FAIL c2_out_data: 0x%h expected 0xa5", out_data); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks += 3;
    if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL c3_out_valid: %b expected 0", out_valid); end
    if (count !== 6'd0)         begin n_fail++; $display("FAIL c3_count: %0d expected 0", count); end
    if (out_data !== 8'hA5)     begin n_fail++; $display("FAIL c3_out_data_hold: 0x%h expected 0xa5", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    int nxt = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; in_data = 8'(nxt);
      @(negedge clk);
      if (in_ready) nxt++;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = 8'h22;
    @(negedge clk);
    n_checks += 4;
    if (nxt != 34)          begin n_fail++; $display("FAIL full_accepts: %0d expected 34", nxt); end
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL full_in_ready: %b expected 0", in_ready); end
    if (mem_wen !== 1'b0)   begin n_fail++; $display("FAIL full_mem_wen: %b expected 0", mem_wen); end
    if (count !== 6'd34)    begin n_fail++; $display("FAIL full_count: %0d expected 34", count); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_left: %0d words expected 0", exp_q.size()); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid: %b expected 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int pops = 0, stalls = 0, first_pop = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 102; c++) begin
      in_valid = (c < 100);
      in_data  = 8'(c + 8'h40);
      @(negedge clk);
      if (in_valid && !in_ready) stalls++;
      if (out_valid) begin
        if (first_pop < 0) first_pop = c;
        pops++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks += 3;
    if (pops != 100)     begin n_fail++; $display("FAIL stream_pops: %0d expected 100", pops); end
    if (stalls != 0)     begin n_fail++; $display("FAIL stream_stalls: %0d expected 0", stalls); end
    if (first_pop != 2)  begin n_fail++; $display("FAIL stream_latency: first pop cycle %0d expected 2", first_pop); end
  endtask

  task automatic test_random();
    int acc = 0;
    for (int c = 0; c < 6000 && acc < 1000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      out_ready = $urandom_range(0, 1);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    n_checks += 2;
    if (acc != 1000)       begin n_fail++; $display("FAIL rand_accepts: %0d expected 1000", acc); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain_left: %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_inflight();
    bit seen = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; in_data = 8'(c + 8'h90);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mem_ren !== 1'b1) begin n_fail++; $display("FAIL rif_read_issue: mem_ren=%b expected 1", mem_ren); end
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks += 3;
    if (count !== 6'd0)     begin n_fail++; $display("FAIL rif_count: %0d expected 0", count); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rif_out_valid: %b expected 0", out_valid); end
    if (mem_ren !== 1'b0)   begin n_fail++; $display("FAIL rif_mem_ren: %b expected 0", mem_ren); end
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        n_checks++;
        if (out_data !== 8'h3C) begin n_fail++; $display("FAIL rif_first_word: 0x%h expected 0x3c", out_data); end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL rif_timeout: out_valid=0 expected 1 within 10 cycles"); end
  endtask

`ifdef SRAM_FIFO_WATERMARK_EN
  task automatic test_watermark();
    int acc = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (overflow !== 1'b0)    begin n_fail++; $display("FAIL wm_ovf_reset: %b expected 0", overflow); end
    if (almost_full !== 1'b0) begin n_fail++; $display("FAIL wm_af_reset: %b expected 0", almost_full); end
    @(posedge clk); #1;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1; in_data = 8'(c);
      @(negedge clk);
      n_checks++;
      if (almost_full !== (acc >= 28)) begin
        n_fail++; $display("FAIL wm_af: almost_full=%b expected %b at %0d words", almost_full, (acc >= 28), acc);
      end
      if (acc == 20) begin
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL wm_ovf_early: %b expected 0", overflow); end
      end
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 60 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks += 2;
    if (overflow !== 1'b1)    begin n_fail++; $display("FAIL wm_ovf_sticky: %b expected 1", overflow); end
    if (almost_full !== 1'b0) begin n_fail++; $display("FAIL wm_af_drained: %b expected 0", almost_full); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL wm_ovf_cleared: %b expected 0", overflow); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_stream();
    test_random();
    test_reset_inflight();
`ifdef SRAM_FIFO_WATERMARK_EN
    test_watermark();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
